// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: default geometry,
// the NOP encoding presented while idle, and the discard FSM states.
package if_fetch_pkg;

  localparam int IF_PC_WIDTH = 10;
  localparam int IF_RESET_PC = 0;
  localparam int IF_DEPTH    = 2;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Headroom on the discard counter: back-to-back redirects can stack
  // several windows of stale responses before memory drains them.
  localparam int DISC_EXTRA_W = 4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Small synchronous FIFO used both as the in-order PC queue and as the
// instruction buffer; head is read straight from the register array.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 42
) (
  input  logic                         clk,
  input  logic                         srst,
  input  logic                         clear,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full      = (count_reg == CNT_W'(DEPTH));
  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  assign head_data = mem_reg[rd_ptr_reg];
  assign do_pop    = pop & ~empty;
  // A pop frees the slot in the same edge, so push is legal even when full.
  assign do_push   = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (srst)
    !(push && full && !pop && !clear));

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: issues word-aligned requests, tags in-order responses
// with their PC, buffers them for decode and discards stale ones after a redirect.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int PC_WIDTH = IF_PC_WIDTH,
  parameter int RESET_PC = IF_RESET_PC,
  parameter int DEPTH    = IF_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                stall,
  output logic                if_valid,
  output logic [PC_WIDTH-1:0] if_pc,
  output logic [31:0]         if_inst
);

  localparam int CNT_W  = cnt_width(DEPTH);
  localparam int OCC_W  = CNT_W + 1;
  localparam int DISC_W = CNT_W + DISC_EXTRA_W;
  localparam int BUF_W  = PC_WIDTH + 32;
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);
  localparam logic [PC_WIDTH-1:0] RESET_ADDR = PC_WIDTH'(RESET_PC) & ALIGN_MASK;

  fetch_state_e        state_reg, state_next;
  logic [PC_WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
  logic [CNT_W-1:0]    out_cnt_reg, out_cnt_next;
  logic [DISC_W-1:0]   disc_cnt_reg, disc_cnt_next;

  logic                granted, discarding, rsp_take, rsp_drop, buf_pop;
  logic                buf_full, buf_empty, pcq_full, pcq_empty;
  logic [CNT_W-1:0]    buf_count, pcq_count;
  logic [PC_WIDTH-1:0] pcq_head;
  logic [BUF_W-1:0]    buf_head;
  logic [OCC_W-1:0]    occupancy, live_after;

  assign discarding = (state_reg == ST_DRAIN);
  assign rsp_take   = imem_rvalid & ~discarding;
  assign rsp_drop   = imem_rvalid & discarding;

  assign if_valid = ~buf_empty;
  assign buf_pop  = if_valid & ~stall;
  assign if_pc    = if_valid ? buf_head[BUF_W-1:32] : '0;
  assign if_inst  = if_valid ? buf_head[31:0] : NOP_INST;

  // Counting this cycle's pop lets a full pipe refill with no bubble; a pop
  // always completes, so a request raised on it never falls back without gnt.
  assign occupancy = OCC_W'(out_cnt_reg) + OCC_W'(buf_count) - OCC_W'(buf_pop);
  assign imem_req  = ~rst & (occupancy < OCC_W'(DEPTH));
  assign imem_addr = fetch_pc_reg;
  assign granted   = imem_req & imem_gnt;

  // Live requests still owed by memory after this edge, before any redirect.
  assign live_after = OCC_W'(out_cnt_reg) + OCC_W'(granted) - OCC_W'(rsp_take);

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    out_cnt_next  = out_cnt_reg;
    disc_cnt_next = disc_cnt_reg - DISC_W'(rsp_drop);
    if (redirect_valid) begin
      fetch_pc_next = redirect_pc & ALIGN_MASK;
      out_cnt_next  = '0;
      disc_cnt_next = disc_cnt_reg - DISC_W'(rsp_drop) + DISC_W'(live_after);
    end else begin
      if (granted) fetch_pc_next = fetch_pc_reg + PC_WIDTH'(4);
      out_cnt_next = CNT_W'(live_after);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN:   if (redirect_valid && (live_after != '0)) state_next = ST_DRAIN;
      ST_DRAIN: if (disc_cnt_next == '0) state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_RUN;
      fetch_pc_reg <= RESET_ADDR;
      out_cnt_reg  <= '0;
      disc_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      out_cnt_reg  <= out_cnt_next;
      disc_cnt_reg <= disc_cnt_next;
    end
  end

  // A request granted on a redirect edge is never queued: it belongs to the discard window.
  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(PC_WIDTH)) u_pc_queue (
    .clk       (clk),
    .srst      (rst),
    .clear     (redirect_valid),
    .push      (granted & ~redirect_valid),
    .push_data (fetch_pc_reg),
    .pop       (rsp_take),
    .head_data (pcq_head),
    .full      (pcq_full),
    .empty     (pcq_empty),
    .count     (pcq_count)
  );

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(BUF_W)) u_inst_buf (
    .clk       (clk),
    .srst      (rst),
    .clear     (redirect_valid),
    .push      (rsp_take & ~redirect_valid),
    .push_data ({pcq_head, imem_rdata}),
    .pop       (buf_pop),
    .head_data (buf_head),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  a_pcq_tracks_outstanding: assert property (@(posedge clk) disable iff (rst)
    pcq_count == out_cnt_reg);
  a_rsp_has_request: assert property (@(posedge clk) disable iff (rst)
    !(rsp_take && pcq_empty));
  a_pcq_room: assert property (@(posedge clk) disable iff (rst)
    !(granted && pcq_full && !rsp_take));
  a_buf_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(rsp_take && !redirect_valid && buf_full && !buf_pop));

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboarded bench for if_fetch: a latency-configurable memory model,
// expected PCs queued by stimulus and compared by a negedge monitor.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam int PCW = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           imem_req;
  logic [PCW-1:0] imem_addr;
  logic           imem_gnt = 1'b0;
  logic           imem_rvalid = 1'b0;
  logic [31:0]    imem_rdata = 32'h0;
  logic           redirect_valid = 1'b0;
  logic [PCW-1:0] redirect_pc = '0;
  logic           stall = 1'b1;
  logic           if_valid;
  logic [PCW-1:0] if_pc;
  logic [31:0]    if_inst;

  if_fetch #(.PC_WIDTH(PCW), .RESET_PC(0), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PCW-1:0] addr;
    int             due;
  } mem_t;

  mem_t           mem_q[$];
  logic [PCW-1:0] exp_q[$];
  int             acc_q[$];
  int             n_cmp = 0;
  int             n_bad = 0;
  int             cyc = 0;
  int             lat = 1;
  int             c0 = 0;
  logic           rst_want = 1'b1;
  logic           gnt_want = 1'b0;
  logic           stall_user = 1'b0;
  logic           redir_pend = 1'b0;
  logic [PCW-1:0] redir_target = '0;
  logic [PCW-1:0] mon_e;

  function automatic logic [31:0] inst_of(input logic [PCW-1:0] a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: records grants into the memory model and scores every accepted instruction.
  always @(negedge clk) begin
    if (!rst && imem_req && imem_gnt)
      mem_q.push_back('{addr: imem_addr, due: cyc + lat});
    if (!rst && if_valid && !stall) begin
      acc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept: unexpected if_pc %h, required no instruction", if_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("accept_pc", 32'(if_pc), 32'(mon_e));
        check("accept_inst", if_inst, inst_of(mon_e));
      end
    end
  end

  // One clock cycle: drive inputs just after the edge, return before the next negedge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    rst            = rst_want;
    imem_gnt       = gnt_want;
    redirect_valid = redir_pend;
    redirect_pc    = redir_target;
    redir_pend     = 1'b0;
    stall          = stall_user || (exp_q.size() == 0);
    if (rst_want) mem_q.delete();
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = inst_of(mem_q[0].addr);
      mem_q.delete(0);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    #3;
  endtask

  task automatic drain(input string name, input int bound);
    int n = 0;
    while (exp_q.size() > 0 && n < bound) begin
      tick();
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: %0d instructions still expected after %0d cycles, required 0",
               name, exp_q.size(), n);
      exp_q.delete();
    end else begin
      $display("ok   %s_drain: done in %0d cycles", name, n);
    end
  endtask

  task automatic do_reset(input string name);
    rst_want   = 1'b1;
    gnt_want   = 1'b0;
    stall_user = 1'b0;
    exp_q.delete();
    acc_q.delete();
    tick();
    tick();
    check({name, "_rst_req"},   32'(imem_req), 32'd0);
    check({name, "_rst_valid"}, 32'(if_valid), 32'd0);
    check({name, "_rst_inst"},  if_inst, 32'h0000_0013);
    check({name, "_rst_pc"},    32'(if_pc), 32'd0);
  endtask

  initial begin
    // Streaming: one instruction per cycle once the pipe fills.
    do_reset("t1");
    lat = 1;
    gnt_want = 1'b1;
    exp_q = '{10'h000, 10'h004, 10'h008, 10'h00C};
    rst_want = 1'b0;
    tick();
    c0 = cyc;
    check("t1_first_req", 32'(imem_req), 32'd1);
    check("t1_first_addr", 32'(imem_addr), 32'h000);
    drain("t1", 20);
    check("t1_accept_count", 32'(acc_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < acc_q.size(); i++)
      check("t1_accept_cycle", 32'(acc_q[i] - c0), 32'(i + 2));

    // Stall: requests stop once DEPTH are held, head stays put, nothing lost on release.
    stall_user = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_req_low", 32'(imem_req), 32'd0);
      check("t2_valid_held", 32'(if_valid), 32'd1);
      check("t2_inst_held", if_inst, inst_of(10'h010));
    end
    exp_q = '{10'h010, 10'h014, 10'h018, 10'h01C};
    stall_user = 1'b0;
    drain("t2", 20);

    // Redirect with two requests outstanding: both stale responses are dropped.
    do_reset("t3");
    lat = 3;
    gnt_want = 1'b1;
    rst_want = 1'b0;
    tick();
    tick();
    redir_pend = 1'b1;
    redir_target = 10'h100;
    exp_q = '{10'h100, 10'h104};
    tick();
    check("t3_req_at_limit", 32'(imem_req), 32'd0);
    tick();
    check("t3_req_target", 32'(imem_req), 32'd1);
    check("t3_addr_target", 32'(imem_addr), 32'h100);
    check("t3_valid_flushed", 32'(if_valid), 32'd0);
    drain("t3", 30);

    // Address held without grant, then 0x3FC wraps to 0x000.
    do_reset("t4");
    lat = 1;
    gnt_want = 1'b0;
    rst_want = 1'b0;
    tick();
    check("t4_req", 32'(imem_req), 32'd1);
    check("t4_addr", 32'(imem_addr), 32'h000);
    tick();
    check("t4_addr_hold", 32'(imem_addr), 32'h000);
    redir_pend = 1'b1;
    redir_target = 10'h3FC;
    tick();
    gnt_want = 1'b1;
    exp_q = '{10'h3FC, 10'h000};
    tick();
    check("t4_addr_3fc", 32'(imem_addr), 32'h3FC);
    tick();
    check("t4_addr_wrap", 32'(imem_addr), 32'h000);
    check("t4_req_wrap", 32'(imem_req), 32'd1);
    drain("t4", 20);

    // Unaligned redirect coincident with a grant and a pop.
    do_reset("t5");
    lat = 1;
    gnt_want = 1'b1;
    exp_q = '{10'h000, 10'h004, 10'h0A4, 10'h0A8};
    rst_want = 1'b0;
    tick();
    tick();
    tick();
    redir_pend = 1'b1;
    redir_target = 10'h0A7;
    tick();
    check("t5_pop_pc", 32'(if_pc), 32'h004);
    check("t5_grant_req", 32'(imem_req), 32'd1);
    tick();
    check("t5_addr_aligned", 32'(imem_addr), 32'h0A4);
    check("t5_req", 32'(imem_req), 32'd1);
    check("t5_buf_empty", 32'(if_valid), 32'd0);
    drain("t5", 20);

    // Reset with the buffer full.
    do_reset("t6");
    lat = 1;
    gnt_want = 1'b1;
    rst_want = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check("t6_full_req", 32'(imem_req), 32'd0);
    check("t6_full_inst", if_inst, inst_of(10'h000));
    rst_want = 1'b1;
    tick();
    check("t6_rst_req", 32'(imem_req), 32'd0);
    rst_want = 1'b0;
    tick();
    check("t6_post_valid", 32'(if_valid), 32'd0);
    check("t6_post_inst", if_inst, 32'h0000_0013);
    check("t6_post_pc", 32'(if_pc), 32'd0);
    check("t6_post_req", 32'(imem_req), 32'd1);
    check("t6_post_addr", 32'(imem_addr), 32'h000);
    exp_q = '{10'h000, 10'h004};
    drain("t6", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
